// File: rtl/xor_pkg.sv
// Shared types for the XOR streaming datapath: per-beat operation codes and FSM states.
package xor_pkg;

  typedef enum logic [1:0] {
    M_XOR  = 2'b00,
    M_XNOR = 2'b01,
    M_AND  = 2'b10,
    M_ACC  = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_op_nbits.sv
// Per-beat combinational operation; ACC contributes a^b to the running frame value.
module logic_op_nbits
  import xor_pkg::*;
#(
  parameter int NB_G = 16
) (
  input  logic [NB_G-1:0] a,
  input  logic [NB_G-1:0] b,
  input  mode_t           mode,
  output logic [NB_G-1:0] result
);

  always_comb begin
    result = '0;
    unique case (mode)
      M_XOR:   result = a ^ b;
      M_XNOR:  result = ~(a ^ b);
      M_AND:   result = a & b;
      M_ACC:   result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/xor_stream_nbits.sv
// Valid/ready streaming XOR/XNOR/AND unit with framed XOR accumulation, saturating
// beat count and a registered result stage that holds under backpressure.
module xor_stream_nbits
  import xor_pkg::*;
#(
  parameter int NB_G  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [NB_G-1:0]  a_i,
  input  logic [NB_G-1:0]  b_i,
  input  logic [1:0]       mode_i,
  input  logic             last_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [NB_G-1:0]  s_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o,
  output logic             parity_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [NB_G-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fsat_q, fsat_d;
  logic             valid_q, valid_d;
  logic [NB_G-1:0]  s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             parity_q, parity_d;

  mode_t            beat_mode;
  logic [NB_G-1:0]  op_res;
  logic [NB_G-1:0]  acc_x;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;
  logic             accept;
  logic             emit;
  logic [NB_G-1:0]  emit_s;
  logic [CNT_W-1:0] emit_cnt;
  logic             emit_sat;

  // Inside an open frame every beat folds as ACC; the frame's mode is fixed at its first beat.
  assign beat_mode = (state_q == S_ACC) ? M_ACC : mode_t'(mode_i);

  logic_op_nbits #(
    .NB_G (NB_G)
  ) u_op (
    .a      (a_i),
    .b      (b_i),
    .mode   (beat_mode),
    .result (op_res)
  );

  assign ready_o = (!valid_q || ready_i) && !flush_i;
  assign accept  = valid_i && ready_o;

  assign acc_x    = acc_q ^ op_res;
  assign cnt_next = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
  assign sat_next = (count_q == CNT_MAX) ? 1'b1 : fsat_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    fsat_d   = fsat_q;
    emit     = 1'b0;
    emit_s   = op_res;
    emit_cnt = CNT_ONE;
    emit_sat = 1'b0;

    if (flush_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      fsat_d  = 1'b0;
    end else if (accept) begin
      if (beat_mode != M_ACC) begin
        emit = 1'b1;
      end else if (state_q == S_IDLE) begin
        if (last_i) begin
          emit = 1'b1;
        end else begin
          state_d = S_ACC;
          acc_d   = op_res;
          count_d = CNT_ONE;
          fsat_d  = 1'b0;
        end
      end else if (last_i) begin
        emit     = 1'b1;
        emit_s   = acc_x;
        emit_cnt = cnt_next;
        emit_sat = sat_next;
        state_d  = S_IDLE;
        acc_d    = '0;
        count_d  = '0;
        fsat_d   = 1'b0;
      end else begin
        acc_d   = acc_x;
        count_d = cnt_next;
        fsat_d  = sat_next;
      end
    end
  end

  // Result stage: reload on an emitting accept, otherwise a handoff drops valid and data holds.
  always_comb begin
    valid_d  = valid_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    parity_d = parity_q;
    if (emit) begin
      valid_d  = 1'b1;
      s_d      = emit_s;
      cnt_d    = emit_cnt;
      sat_d    = emit_sat;
      parity_d = ^emit_s;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      fsat_q   <= 1'b0;
      valid_q  <= 1'b0;
      s_q      <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      fsat_q   <= fsat_d;
      valid_q  <= valid_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      parity_q <= parity_d;
    end
  end

  assign valid_o  = valid_q;
  assign s_o      = s_q;
  assign cnt_o    = cnt_q;
  assign sat_o    = sat_q;
  assign parity_o = parity_q;
  assign busy_o   = (state_q == S_ACC);

endmodule

// File: tb/tb_xor_stream_nbits.sv
// Directed bench for xor_stream_nbits: default instance plus a CNT_W=2 instance for saturation.
module tb_xor_stream_nbits;

  logic        clk;
  logic        rst_ni;
  logic        valid_i, ready_i, last_i, flush_i;
  logic [15:0] a_i, b_i;
  logic [1:0]  mode_i;
  logic        ready_o, valid_o, sat_o, parity_o, busy_o;
  logic [15:0] s_o;
  logic [7:0]  cnt_o;

  logic        valid2_i, ready2_i, last2_i, flush2_i;
  logic [15:0] a2_i, b2_i;
  logic [1:0]  mode2_i;
  logic        ready2_o, valid2_o, sat2_o, parity2_o, busy2_o;
  logic [15:0] s2_o;
  logic [1:0]  cnt2_o;

  int checks = 0;
  int errors = 0;

  xor_stream_nbits #(.NB_G(16), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .mode_i(mode_i), .last_i(last_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .cnt_o(cnt_o),
    .sat_o(sat_o), .parity_o(parity_o), .busy_o(busy_o)
  );

  xor_stream_nbits #(.NB_G(16), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid2_i), .ready_o(ready2_o),
    .a_i(a2_i), .b_i(b2_i), .mode_i(mode2_i), .last_i(last2_i), .flush_i(flush2_i),
    .valid_o(valid2_o), .ready_i(ready2_i), .s_o(s2_o), .cnt_o(cnt2_o),
    .sat_o(sat2_o), .parity_o(parity2_o), .busy_o(busy2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] m, input logic l);
    valid_i = v; a_i = a; b_i = b; mode_i = m; last_i = l;
  endtask

  task automatic beat2(input logic v, input logic [15:0] a, input logic l);
    valid2_i = v; a2_i = a; b2_i = 16'h0000; mode2_i = 2'b11; last2_i = l;
  endtask

  initial begin
    rst_ni = 1'b0;
    beat(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    flush_i = 1'b0; ready_i = 1'b1;
    beat2(1'b0, 16'h0, 1'b0);
    flush2_i = 1'b0; ready2_i = 1'b1;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_s",     32'(s_o),     32'd0);
    chk("rst_cnt",   32'(cnt_o),   32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);

    // XOR single beat right after reset release
    @(negedge clk);
    rst_ni = 1'b1;
    beat(1'b1, 16'h0000, 16'hFFFF, 2'b00, 1'b0);
    #1;
    chk("ready_after_rst", 32'(ready_o), 32'd1);
    tick();
    chk("xor_valid",  32'(valid_o),  32'd1);
    chk("xor_s",      32'(s_o),      32'h0000FFFF);
    chk("xor_cnt",    32'(cnt_o),    32'd1);
    chk("xor_parity", 32'(parity_o), 32'd0);
    chk("xor_sat",    32'(sat_o),    32'd0);
    beat(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    tick();
    chk("xor_valid_drop", 32'(valid_o), 32'd0);

    // ACC frame of three beats
    beat(1'b1, 16'h00FF, 16'h0000, 2'b11, 1'b0);
    tick();
    chk("acc1_busy",  32'(busy_o),  32'd1);
    chk("acc1_valid", 32'(valid_o), 32'd0);
    beat(1'b1, 16'h0F0F, 16'h0000, 2'b11, 1'b0);
    tick();
    chk("acc2_busy", 32'(busy_o), 32'd1);
    beat(1'b1, 16'hFFFF, 16'h0001, 2'b11, 1'b1);
    tick();
    chk("acc_valid",  32'(valid_o),  32'd1);
    chk("acc_s",      32'(s_o),      32'h0000F00E);
    chk("acc_cnt",    32'(cnt_o),    32'd3);
    chk("acc_parity", 32'(parity_o), 32'd1);
    chk("acc_busy",   32'(busy_o),   32'd0);

    // Backpressure on the pending ACC result
    ready_i = 1'b0;
    beat(1'b1, 16'h1234, 16'h00FF, 2'b00, 1'b0);
    #1;
    chk("bp_ready", 32'(ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_s",     32'(s_o),     32'h0000F00E);
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_ready", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_o), 32'd1);
    tick();
    chk("bp_reload_valid", 32'(valid_o), 32'd1);
    chk("bp_reload_s",     32'(s_o),     32'h000012CB);
    chk("bp_reload_cnt",   32'(cnt_o),   32'd1);

    // Back-to-back XNOR and AND
    beat(1'b1, 16'hFF00, 16'h0F0F, 2'b01, 1'b0);
    tick();
    chk("xnor_s",      32'(s_o),      32'h00000FF0);
    chk("xnor_parity", 32'(parity_o), 32'd0);
    beat(1'b1, 16'hF0F0, 16'hFF00, 2'b10, 1'b0);
    tick();
    chk("and_s",     32'(s_o),     32'h0000F000);
    chk("and_valid", 32'(valid_o), 32'd1);
    beat(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    tick();
    chk("and_drop", 32'(valid_o), 32'd0);

    // Flush an open frame; second beat uses mode XOR but must fold as ACC
    beat(1'b1, 16'h1111, 16'h0000, 2'b11, 1'b0);
    tick();
    beat(1'b1, 16'h2222, 16'h0000, 2'b00, 1'b0);
    tick();
    chk("fl_mode_ignored_valid", 32'(valid_o), 32'd0);
    chk("fl_mode_ignored_busy",  32'(busy_o),  32'd1);
    beat(1'b1, 16'hABCD, 16'h0000, 2'b11, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("fl_ready", 32'(ready_o), 32'd0);
    tick();
    chk("fl_busy",       32'(busy_o),  32'd0);
    chk("fl_no_accept",  32'(valid_o), 32'd0);
    flush_i = 1'b0;
    beat(1'b1, 16'h1234, 16'h0000, 2'b11, 1'b1);
    tick();
    chk("fl_next_valid", 32'(valid_o), 32'd1);
    chk("fl_next_s",     32'(s_o),     32'h00001234);
    chk("fl_next_cnt",   32'(cnt_o),   32'd1);
    beat(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    tick();

    // Reset during an open frame
    beat(1'b1, 16'hAAAA, 16'h0000, 2'b11, 1'b0);
    tick();
    chk("mid_busy", 32'(busy_o), 32'd1);
    beat(1'b1, 16'h5555, 16'h0000, 2'b11, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid",  32'(valid_o),  32'd0);
    chk("arst_s",      32'(s_o),      32'd0);
    chk("arst_cnt",    32'(cnt_o),    32'd0);
    chk("arst_parity", 32'(parity_o), 32'd0);
    chk("arst_busy",   32'(busy_o),   32'd0);
    beat(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_valid", 32'(valid_o), 32'd0);
    chk("post_rst_busy",  32'(busy_o),  32'd0);
    tick();
    chk("post_rst_valid2", 32'(valid_o), 32'd0);

    // Saturation on the CNT_W=2 instance: five-beat frame
    beat2(1'b1, 16'h0001, 1'b0); tick();
    beat2(1'b1, 16'h0002, 1'b0); tick();
    beat2(1'b1, 16'h0004, 1'b0); tick();
    beat2(1'b1, 16'h0008, 1'b0); tick();
    chk("sat_busy", 32'(busy2_o), 32'd1);
    beat2(1'b1, 16'h0010, 1'b1); tick();
    chk("sat_valid",  32'(valid2_o),  32'd1);
    chk("sat_s",      32'(s2_o),      32'h0000001F);
    chk("sat_cnt",    32'(cnt2_o),    32'd3);
    chk("sat_flag",   32'(sat2_o),    32'd1);
    chk("sat_parity", 32'(parity2_o), 32'd1);
    beat2(1'b1, 16'h00F0, 1'b1); tick();
    chk("sat_clear_flag", 32'(sat2_o), 32'd0);
    chk("sat_clear_cnt",  32'(cnt2_o), 32'd1);
    beat2(1'b0, 16'h0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_stream_nbits.md
XOR_STREAM_NBITS -- requirements
Module: xor_stream_nbits

Interface
REQ-001 Parameter NB_G, default 16, data width in bits (>=1).
REQ-002 Parameter CNT_W, default 8, beat-counter width in bits (>=2).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  input beat valid.
REQ-006 ready_o  output  1  block accepts a beat; accept = valid_i && ready_o.
REQ-007 a_i  input  NB_G  operand A.
REQ-008 b_i  input  NB_G  operand B.
REQ-009 mode_i  input  2  operation: 00 XOR, 01 XNOR, 10 AND, 11 ACC (frame XOR accumulate).
REQ-010 last_i  input  1  final beat of an ACC frame; ignored in other modes.
REQ-011 flush_i  input  1  synchronous abort of an ACC frame in progress.
REQ-012 valid_o  output  1  result valid.
REQ-013 ready_i  input  1  downstream accepts result; handoff = valid_o && ready_i.
REQ-014 s_o  output  NB_G  result word.
REQ-015 cnt_o  output  CNT_W  number of beats folded into s_o, saturating.
REQ-016 sat_o  output  1  cnt_o saturated for this result.
REQ-017 parity_o  output  1  XOR-reduction of s_o, registered with s_o.
REQ-018 busy_o  output  1  high while an ACC frame is open.

Function
REQ-019 ready_o SHALL be (!valid_o || ready_i) && !flush_i.
REQ-020 FSM states SHALL be S_IDLE and S_ACC; busy_o = (state == S_ACC).
REQ-021 In S_IDLE, an accepted beat with mode 00/01/10 SHALL load s_o with a^b, ~(a^b) or a&b respectively, with cnt_o=1, sat_o=0, and valid_o=1 on the next edge (latency 1).
REQ-022 In S_IDLE, an accepted ACC beat with last_i=1 SHALL emit s_o=a^b with cnt_o=1 and remain in S_IDLE.
REQ-023 In S_IDLE, an accepted ACC beat with last_i=0 SHALL set acc=a^b and count=1, move to S_ACC, and leave valid_o unchanged.
REQ-024 In S_ACC, every accepted beat SHALL be treated as ACC regardless of mode_i; the mode is latched at frame start.
REQ-025 In S_ACC, an accepted beat with last_i=0 SHALL update acc ^= a^b and increment count.
REQ-026 In S_ACC, an accepted beat with last_i=1 SHALL emit s_o=acc^a^b and cnt_o=count+1, then return to S_IDLE.
REQ-027 The count SHALL saturate at 2^CNT_W-1; sat_o=1 on the emitted result if saturation occurred in that frame.
REQ-028 flush_i=1 SHALL clear acc and count and force S_IDLE on the next edge; no beat is accepted that cycle; a pending output is unaffected.
REQ-029 While valid_o && !ready_i, s_o, cnt_o, sat_o and parity_o SHALL hold stable.
REQ-030 A handoff without a new emitting accept SHALL clear valid_o; a handoff and an emitting accept in the same cycle SHALL reload the output with valid_o staying 1.

Reset
REQ-031 rst_ni low SHALL immediately force valid_o=0, s_o=0, cnt_o=0, sat_o=0, parity_o=0, busy_o=0, acc=0, count=0, state=S_IDLE.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no result is emitted after deassertion.
REQ-033 ready_o SHALL be 1 in the first cycle after reset release when flush_i=0.

Structure
REQ-034 Package xor_pkg SHALL hold mode_t (2-bit enum XOR/XNOR/AND/ACC) and state_t (S_IDLE/S_ACC).
REQ-035 Combinational sub-module logic_op_nbits (parameter NB_G; inputs a, b, mode; output result) SHALL implement the per-beat operation; xor_stream_nbits instantiates it once.

Verification (NB_G=16, CNT_W=8 unless stated)
REQ-036 Reset: pulse rst_ni low during an open ACC frame -> all outputs are 0 asynchronously and no result follows.
REQ-037 XOR: a=0x0000, b=0xFFFF, mode 00, ready_i=1 -> next cycle s_o=0xFFFF, cnt_o=1, parity_o=0, valid_o=1 for one cycle.
REQ-038 ACC frame: (0x00FF,0x0000), (0x0F0F,0x0000), (0xFFFF,0x0001, last) -> s_o=0xF00E, cnt_o=3, parity_o=1, busy_o high between first and last beat.
REQ-039 Backpressure: ready_i=0 for 5 cycles with a result pending -> ready_o=0 and s_o stable; raise ready_i -> the next beat is accepted the same cycle.
REQ-040 Flush: 2 ACC beats, then flush_i=1 -> busy_o=0; next ACC beat (0x1234,0x0000, last) -> s_o=0x1234, cnt_o=1.
REQ-041 Saturation with CNT_W=2: 5-beat ACC frame -> cnt_o=3, sat_o=1.
